// File: rtl/input_conditioner.sv
// Per-channel 2-flop synchronizer and counter debouncer for slide switches and push buttons.
// Emits a clean registered level, one-cycle rise/fall pulses, and a pending-change flag.
module input_conditioner #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] stable_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] busy_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  sync_p0;
    logic [N_CH-1:0]  sync_p1;
    logic [CNT_W-1:0] cnt_p2 [N_CH];

    // Holds at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    // Stage p0/p1: metastability synchronizer, straight flop-to-flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_i;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounce counter, accepted level and edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_p2[i] <= '0;
            end
            stable_o <= '0;
            rise_o   <= '0;
            fall_o   <= '0;
            busy_o   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                rise_o[i] <= 1'b0;
                fall_o[i] <= 1'b0;
                if (sync_p1[i] == stable_o[i]) begin
                    cnt_p2[i] <= '0;
                    busy_o[i] <= 1'b0;
                end else if (cnt_p2[i] == CNT_MAX) begin
                    stable_o[i] <= sync_p1[i];
                    rise_o[i]   <= sync_p1[i];
                    fall_o[i]   <= ~sync_p1[i];
                    cnt_p2[i]   <= '0;
                    busy_o[i]   <= 1'b0;
                end else begin
                    cnt_p2[i] <= sat_inc(cnt_p2[i]);
                    busy_o[i] <= 1'b1;
                end
            end
        end
    end

endmodule
